// File: rtl/nec_ir_transmitter.sv
// NEC IR transmitter: leader, addr/~addr/cmd/~cmd LSB-first, stop burst,
// optional repeat codes, with optional carrier modulation of every burst.
module nec_ir_transmitter #(
  parameter int TICK_DIV    = 22500,
  parameter int CARRIER_DIV = 526,
  parameter bit ACTIVE_LOW  = 1'b0
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       start_i,
  input  logic [7:0] addr_i,
  input  logic [7:0] cmd_i,
  input  logic       repeat_i,
  input  logic       carrier_en_i,
  output logic       ready_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       ir_o
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;
  localparam logic [PW-1:0] TICK_MAX = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CAR_MAX = CW'(CARRIER_DIV - 1);
  localparam logic ACT = !ACTIVE_LOW;
  localparam logic IDL = ACTIVE_LOW;
  localparam logic [7:0] PERIOD_LAST = 8'd191;
  localparam logic [7:0] PERIOD_SAT = 8'd192;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEAD_MARK,
    S_LEAD_SPACE,
    S_BIT_MARK,
    S_BIT_SPACE,
    S_STOP_MARK,
    S_GAP,
    S_REP_MARK,
    S_REP_SPACE,
    S_REP_STOP
  } state_t;

  state_t        state;
  logic [31:0]   sreg;
  logic [5:0]    bits;
  logic [4:0]    dur;
  logic [7:0]    period;
  logic [PW-1:0] presc;
  logic [CW-1:0] car_cnt;
  logic          car_ph;

  logic          tick;
  logic          in_mark;
  logic          car_wrap;
  logic [CW-1:0] car_cnt_n;
  logic          car_ph_n;
  logic          mark_lvl;

  assign ready_o = (state == S_IDLE);
  assign busy_o = ~ready_o;
  assign tick = busy_o && (presc == TICK_MAX);
  assign in_mark = (state == S_LEAD_MARK) || (state == S_BIT_MARK) ||
                   (state == S_STOP_MARK) || (state == S_REP_MARK) ||
                   (state == S_REP_STOP);

  // Carrier phase as it will be in the next cycle if the mark continues.
  assign car_wrap = (car_cnt == CAR_MAX);
  assign car_cnt_n = car_wrap ? '0 : car_cnt + 1'b1;
  assign car_ph_n = car_wrap ? ~car_ph : car_ph;
  assign mark_lvl = (carrier_en_i && !car_ph_n) ? IDL : ACT;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state   <= S_IDLE;
      sreg    <= '0;
      bits    <= '0;
      dur     <= '0;
      period  <= '0;
      presc   <= '0;
      car_cnt <= '0;
      car_ph  <= 1'b0;
      done_o  <= 1'b0;
      ir_o    <= IDL;
    end else begin
      done_o <= 1'b0;
      ir_o   <= in_mark ? mark_lvl : IDL;
      if (in_mark) begin
        car_cnt <= car_cnt_n;
        car_ph  <= car_ph_n;
      end
      if (busy_o) presc <= tick ? '0 : presc + 1'b1;
      if (tick && state != S_GAP) dur <= dur + 1'b1;
      if (tick && period != PERIOD_SAT) period <= period + 1'b1;

      // Mark entries restart the carrier at the active level.
      unique case (state)
        S_IDLE: if (start_i) begin
          sreg    <= {~cmd_i, cmd_i, ~addr_i, addr_i};
          bits    <= '0;
          dur     <= '0;
          presc   <= '0;
          period  <= '0;
          car_cnt <= '0;
          car_ph  <= 1'b1;
          ir_o    <= ACT;
          state   <= S_LEAD_MARK;
        end
        S_LEAD_MARK: if (tick && dur == 5'd15) begin
          dur   <= '0;
          ir_o  <= IDL;
          state <= S_LEAD_SPACE;
        end
        S_LEAD_SPACE: if (tick && dur == 5'd7) begin
          dur     <= '0;
          car_cnt <= '0;
          car_ph  <= 1'b1;
          ir_o    <= ACT;
          state   <= S_BIT_MARK;
        end
        S_BIT_MARK: if (tick) begin
          dur   <= '0;
          ir_o  <= IDL;
          state <= S_BIT_SPACE;
        end
        S_BIT_SPACE: if (tick && dur == (sreg[0] ? 5'd2 : 5'd0)) begin
          sreg    <= sreg >> 1;
          bits    <= bits + 1'b1;
          dur     <= '0;
          car_cnt <= '0;
          car_ph  <= 1'b1;
          ir_o    <= ACT;
          state   <= (bits == 6'd31) ? S_STOP_MARK : S_BIT_MARK;
        end
        S_STOP_MARK: if (tick) begin
          dur   <= '0;
          ir_o  <= IDL;
          state <= S_GAP;
        end
        S_GAP: if (tick && period == PERIOD_LAST) begin
          dur <= '0;
          if (repeat_i) begin
            period  <= '0;
            car_cnt <= '0;
            car_ph  <= 1'b1;
            ir_o    <= ACT;
            state   <= S_REP_MARK;
          end else begin
            done_o <= 1'b1;
            state  <= S_IDLE;
          end
        end
        S_REP_MARK: if (tick && dur == 5'd15) begin
          dur   <= '0;
          ir_o  <= IDL;
          state <= S_REP_SPACE;
        end
        S_REP_SPACE: if (tick && dur == 5'd3) begin
          dur     <= '0;
          car_cnt <= '0;
          car_ph  <= 1'b1;
          ir_o    <= ACT;
          state   <= S_REP_STOP;
        end
        S_REP_STOP: if (tick) begin
          dur   <= '0;
          ir_o  <= IDL;
          state <= S_GAP;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nec_ir_transmitter.sv
// Directed bench with a per-cycle scoreboard of {ir, done, ready, busy}
// covering frames, repeats, carrier, held start and mid-frame reset.
module tb_nec_ir_transmitter;
  localparam int TD = 8;
  localparam int CD = 2;
  localparam int PERIOD = 192;

  logic       wb_clk_i = 1'b0;
  logic       wb_rst_i;
  logic       start_i;
  logic [7:0] addr_i;
  logic [7:0] cmd_i;
  logic       repeat_i;
  logic       carrier_en_i;
  logic       ready_o;
  logic       busy_o;
  logic       done_o;
  logic       ir_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  logic [3:0] exp_q[$];

  nec_ir_transmitter #(
    .TICK_DIV(TD),
    .CARRIER_DIV(CD),
    .ACTIVE_LOW(1'b0)
  ) dut (
    .wb_clk_i(wb_clk_i),
    .wb_rst_i(wb_rst_i),
    .start_i(start_i),
    .addr_i(addr_i),
    .cmd_i(cmd_i),
    .repeat_i(repeat_i),
    .carrier_en_i(carrier_en_i),
    .ready_o(ready_o),
    .busy_o(busy_o),
    .done_o(done_o),
    .ir_o(ir_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Busy cycles of one segment: {ir, done=0, ready=0, busy=1}.
  task automatic push_seg(input bit mark, input int ticks, input bit car);
    logic lvl;
    for (int k = 0; k < ticks * TD; k++) begin
      lvl = mark && (!car || ((k / CD) % 2 == 0));
      exp_q.push_back({lvl, 1'b0, 1'b0, 1'b1});
    end
  endtask

  task automatic push_frame(input logic [7:0] a, input logic [7:0] c,
                            input int reps, input bit car);
    logic [31:0] w;
    int t;
    w = {~c, c, ~a, a};
    push_seg(1'b1, 16, car);
    push_seg(1'b0, 8, car);
    t = 24;
    for (int i = 0; i < 32; i++) begin
      push_seg(1'b1, 1, car);
      push_seg(1'b0, w[i] ? 3 : 1, car);
      t += w[i] ? 4 : 2;
    end
    push_seg(1'b1, 1, car);
    push_seg(1'b0, PERIOD - t - 1, car);
    for (int r = 0; r < reps; r++) begin
      push_seg(1'b1, 16, car);
      push_seg(1'b0, 4, car);
      push_seg(1'b1, 1, car);
      push_seg(1'b0, PERIOD - 21, car);
    end
    exp_q.push_back(4'b0110);
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] c,
                      input int reps);
    @(negedge wb_clk_i);
    chk("ready_before_start", ready_o, 1);
    start_i = 1'b1;
    addr_i = a;
    cmd_i = c;
    push_frame(a, c, reps, carrier_en_i);
    @(negedge wb_clk_i);
    start_i = 1'b0;
    addr_i = ~a;
    cmd_i = ~c;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20000) begin
      @(negedge wb_clk_i);
      n++;
    end
    chk("frame_drained", exp_q.size(), 0);
  endtask

  initial begin
    logic [3:0] obs;
    logic [3:0] exp;
    string tag;
    forever begin
      @(posedge wb_clk_i);
      #2;
      cyc++;
      if (mon_en) begin
        obs = {ir_o, done_o, ready_o, busy_o};
        if (exp_q.size() != 0) begin
          exp = exp_q.pop_front();
          tag = "frame";
        end else begin
          exp = 4'b0010;
          tag = "idle";
        end
        checks++;
        assert (obs === exp) else begin
          errors++;
          $error("FAIL %s cycle %0d: ir/done/ready/busy observed %b expected %b",
                 tag, cyc, obs, exp);
        end
      end
    end
  end

  initial begin
    logic [7:0] a;
    logic [7:0] c;
    logic [31:0] w;
    int t;

    wb_rst_i = 1'b1;
    start_i = 1'b0;
    addr_i = '0;
    cmd_i = '0;
    repeat_i = 1'b0;
    carrier_en_i = 1'b0;
    repeat (3) @(negedge wb_clk_i);
    chk("reset_ready", ready_o, 1);
    chk("reset_busy", busy_o, 0);
    chk("reset_done", done_o, 0);
    chk("reset_ir", ir_o, 0);
    wb_rst_i = 1'b0;
    mon_en = 1'b1;

    send(8'h00, 8'hFF, 0);
    drain();

    send(8'hA5, 8'h3C, 0);
    drain();

    repeat_i = 1'b1;
    send(8'h12, 8'h34, 2);
    repeat (2 * PERIOD * TD + 600) @(negedge wb_clk_i);
    repeat_i = 1'b0;
    drain();

    carrier_en_i = 1'b1;
    send(8'hC3, 8'h81, 0);
    drain();
    carrier_en_i = 1'b0;

    // start held high: second frame accepted in the done cycle
    @(negedge wb_clk_i);
    chk("ready_hold", ready_o, 1);
    start_i = 1'b1;
    addr_i = 8'h3E;
    cmd_i = 8'h91;
    push_frame(8'h3E, 8'h91, 0, 1'b0);
    push_frame(8'hC7, 8'h05, 0, 1'b0);
    repeat (200) @(negedge wb_clk_i);
    addr_i = 8'hC7;
    cmd_i = 8'h05;
    repeat (PERIOD * TD) @(negedge wb_clk_i);
    addr_i = 8'h00;
    cmd_i = 8'hEE;
    start_i = 1'b0;
    drain();

    a = 8'h5A;
    c = 8'h6B;
    send(a, c, 0);
    w = {~c, c, ~a, a};
    t = 24;
    for (int i = 0; i < 9; i++) t += w[i] ? 4 : 2;
    repeat (t * TD + 3) @(negedge wb_clk_i);
    chk("bit9_mark", ir_o, 1);
    wb_rst_i = 1'b1;
    exp_q.delete();
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    chk("abort_ir", ir_o, 0);
    chk("abort_ready", ready_o, 1);
    chk("abort_done", done_o, 0);
    repeat (5) @(negedge wb_clk_i);

    a = 8'($urandom);
    c = 8'($urandom);
    send(a, c, 0);
    drain();
    repeat (10) @(negedge wb_clk_i);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
